// File: rtl/countdown_timer_n.sv
// Programmable interval timer: prescaled countdown with one-shot / auto-reload modes,
// pause and stop control, a registered done pulse and a completed-period counter.
module countdown_timer_n #(
  parameter int WIDTH    = 7,
  parameter int PRESCALE = 1,
  parameter int PCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              auto_reload,
  input  logic [WIDTH-1:0]  preset_value,
  output logic [WIDTH-1:0]  count_out,
  output logic              active,
  output logic              done,
  output logic [PCNT_W-1:0] period_cnt,
  output logic [1:0]        state_dbg
);
  localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  // state_dbg encoding: 0 = IDLE, 1 = RUN, 2 = PAUSED
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [PSC_W-1:0]  psc, psc_nxt;
  logic [WIDTH-1:0]  reload, reload_nxt, count_nxt;
  logic [PCNT_W-1:0] pcnt_nxt;
  logic              mode_ar, mode_ar_nxt;
  logic              done_nxt;
  logic              run_slot, tick, terminal;

  // Priority stop > start > pause > tick: the prescaler only advances in an uncontested RUN cycle.
  assign run_slot = (state == ST_RUN) && !pause && !stop && !start;
  assign tick     = run_slot && (psc == PSC_LAST);
  assign terminal = tick && (count_out == CNT_ONE);

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else if (start) begin
      state_nxt = (preset_value != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_RUN: begin
          if (pause) begin
            state_nxt = ST_PAUSED;
          end else if (terminal && !mode_ar) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_nxt = ST_RUN;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    count_nxt   = count_out;
    psc_nxt     = psc;
    reload_nxt  = reload;
    mode_ar_nxt = mode_ar;
    pcnt_nxt    = period_cnt;
    done_nxt    = 1'b0;
    if (stop) begin
      psc_nxt = '0;
    end else if (start) begin
      count_nxt   = preset_value;
      reload_nxt  = preset_value;
      mode_ar_nxt = auto_reload;
      psc_nxt     = '0;
      pcnt_nxt    = '0;
      done_nxt    = (preset_value == '0);
    end else if (run_slot) begin
      if (tick) begin
        psc_nxt = '0;
        if (terminal) begin
          done_nxt  = 1'b1;
          pcnt_nxt  = period_cnt + PCNT_W'(1);
          // Auto-reload jumps straight from 1 to the reload value, so 0 is never shown.
          count_nxt = mode_ar ? reload : '0;
        end else begin
          count_nxt = count_out - CNT_ONE;
        end
      end else begin
        psc_nxt = psc + PSC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out  <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
      period_cnt <= '0;
      psc        <= '0;
      reload     <= '0;
      mode_ar    <= 1'b0;
    end else begin
      count_out  <= count_nxt;
      active     <= (state_nxt != ST_IDLE);
      done       <= done_nxt;
      period_cnt <= pcnt_nxt;
      psc        <= psc_nxt;
      reload     <= reload_nxt;
      mode_ar    <= mode_ar_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer_n.sv
// Bench for countdown_timer_n: three instances (PRESCALE 1/2/3) share stimulus and are
// checked against a behavioural model, plus a vector table and directed corner sequences.
module tb_countdown_timer_n;
  localparam int W  = 7;
  localparam int PW = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, stop = 1'b0, pause = 1'b0, auto_reload = 1'b0;
  logic [W-1:0] preset_value = '0;

  logic [W-1:0]  cnt_o  [3];
  logic          act_o  [3];
  logic          done_o [3];
  logic [PW-1:0] pc_o   [3];
  logic [1:0]    dbg_o  [3];

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  countdown_timer_n #(.WIDTH(W), .PRESCALE(1), .PCNT_W(PW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .auto_reload(auto_reload), .preset_value(preset_value), .count_out(cnt_o[0]),
    .active(act_o[0]), .done(done_o[0]), .period_cnt(pc_o[0]), .state_dbg(dbg_o[0]));
  countdown_timer_n #(.WIDTH(W), .PRESCALE(2), .PCNT_W(PW)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .auto_reload(auto_reload), .preset_value(preset_value), .count_out(cnt_o[1]),
    .active(act_o[1]), .done(done_o[1]), .period_cnt(pc_o[1]), .state_dbg(dbg_o[1]));
  countdown_timer_n #(.WIDTH(W), .PRESCALE(3), .PCNT_W(PW)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .auto_reload(auto_reload), .preset_value(preset_value), .count_out(cnt_o[2]),
    .active(act_o[2]), .done(done_o[2]), .period_cnt(pc_o[2]), .state_dbg(dbg_o[2]));

  // ---------------- behavioural model ----------------
  // Mode: 0 idle, 1 running, 2 paused. Counts are plain integers.
  int ps_of [3] = '{1, 2, 3};
  int m_st [3], m_cnt [3], m_psc [3], m_rel [3], m_ar [3], m_pc [3], m_done [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_psc[i] = 0; m_rel[i] = 0;
      m_ar[i] = 0; m_pc[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 0;
      if (stop) begin
        m_st[i] = 0;
        m_psc[i] = 0;
      end else if (start) begin
        m_cnt[i] = int'(preset_value);
        m_rel[i] = int'(preset_value);
        m_ar[i]  = int'(auto_reload);
        m_psc[i] = 0;
        m_pc[i]  = 0;
        if (preset_value != 0) m_st[i] = 1;
        else begin
          m_st[i] = 0;
          m_done[i] = 1;
        end
      end else if (m_st[i] == 1 && pause) begin
        m_st[i] = 2;
      end else if (m_st[i] == 2 && !pause) begin
        m_st[i] = 1;
      end else if (m_st[i] == 1) begin
        if (m_psc[i] + 1 == ps_of[i]) begin
          m_psc[i] = 0;
          if (m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
          else begin
            m_done[i] = 1;
            m_pc[i] = (m_pc[i] + 1) % (1 << PW);
            if (m_ar[i] != 0) m_cnt[i] = m_rel[i];
            else begin
              m_cnt[i] = 0;
              m_st[i] = 0;
            end
          end
        end else begin
          m_psc[i] = m_psc[i] + 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model%0d_count", i), 32'(cnt_o[i]), m_cnt[i]);
      chk($sformatf("model%0d_active", i), 32'(act_o[i]), (m_st[i] != 0) ? 1 : 0);
      chk($sformatf("model%0d_done", i), 32'(done_o[i]), m_done[i]);
      chk($sformatf("model%0d_period", i), 32'(pc_o[i]), m_pc[i]);
      chk($sformatf("model%0d_state", i), 32'(dbg_o[i]), m_st[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: inputs were set before the edge; outputs are sampled 1ns after it.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic drive(input logic st, input logic sp, input logic pa, input logic ar, input int p);
    start = st; stop = sp; pause = pa; auto_reload = ar; preset_value = W'(p);
  endtask

  // ---------------- vector table (PRESCALE=1 instance) ----------------
  typedef struct packed {
    logic         st, sp, pa, ar;
    logic [W-1:0] p;
    logic [W-1:0] e_cnt;
    logic         e_act, e_done;
    logic [PW-1:0] e_pc;
  } vec_t;
  vec_t tv [$];

  task automatic add(input logic st, input logic sp, input logic pa, input logic ar, input int p,
                     input int e_cnt, input logic e_act, input logic e_done, input int e_pc);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.ar = ar; v.p = W'(p);
    v.e_cnt = W'(e_cnt); v.e_act = e_act; v.e_done = e_done; v.e_pc = PW'(e_pc);
    tv.push_back(v);
  endtask

  logic [W-1:0] exp_q [$];

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int n;
    int got;
    // one-shot P=5
    add(1,0,0,0,5, 5,1,0,0); add(0,0,0,0,0, 4,1,0,0); add(0,0,0,0,0, 3,1,0,0);
    add(0,0,0,0,0, 2,1,0,0); add(0,0,0,0,0, 1,1,0,0); add(0,0,0,0,0, 0,0,1,1);
    add(0,0,0,0,0, 0,0,0,1);
    // zero preset, then start+stop together
    add(1,0,0,0,0, 0,0,1,0); add(1,1,0,0,9, 0,0,0,0);
    // stop at 6
    add(1,0,0,0,8, 8,1,0,0); add(0,0,0,0,0, 7,1,0,0); add(0,0,0,0,0, 6,1,0,0);
    add(0,1,0,0,0, 6,0,0,0); add(0,0,0,0,0, 6,0,0,0);
    // auto-reload P=3 with a pause
    add(1,0,0,1,3, 3,1,0,0); add(0,0,0,0,0, 2,1,0,0); add(0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0, 3,1,1,1); add(0,0,0,0,0, 2,1,0,1); add(0,0,1,0,0, 2,1,0,1);
    add(0,0,1,0,0, 2,1,0,1); add(0,0,0,0,0, 2,1,0,1); add(0,0,0,0,0, 1,1,0,1);
    add(0,0,0,0,0, 3,1,1,2);
    // start held high keeps reloading, then stop
    add(1,0,0,0,4, 4,1,0,0); add(1,0,0,0,4, 4,1,0,0); add(0,1,0,0,0, 4,0,0,0);

    // reset held with start high
    model_reset();
    drive(1, 0, 0, 0, 5);
    rst_n = 1'b0;
    repeat (20) begin
      cycle();
      chk("reset_count", 32'(cnt_o[0]), 0);
      chk("reset_active", 32'(act_o[0]), 0);
      chk("reset_done", 32'(done_o[0]), 0);
      chk("reset_period", 32'(pc_o[0]), 0);
    end
    rst_n = 1'b1;

    for (int r = 0; r < tv.size(); r++) begin
      drive(tv[r].st, tv[r].sp, tv[r].pa, tv[r].ar, int'(tv[r].p));
      cycle();
      chk($sformatf("vec%0d_count", r), 32'(cnt_o[0]), 32'(tv[r].e_cnt));
      chk($sformatf("vec%0d_active", r), 32'(act_o[0]), 32'(tv[r].e_act));
      chk($sformatf("vec%0d_done", r), 32'(done_o[0]), 32'(tv[r].e_done));
      chk($sformatf("vec%0d_period", r), 32'(pc_o[0]), 32'(tv[r].e_pc));
    end
    drive(0, 0, 0, 0, 0);
    cycle();

    // PRESCALE=3, P=10, 7-cycle pause after 12 cycles: terminal 38 edges after load
    drive(1, 0, 0, 0, 10);
    cycle();
    drive(0, 0, 0, 0, 0);
    n = 0;
    repeat (12) begin cycle(); n++; end
    chk("ps3_count_before_pause", 32'(cnt_o[2]), 6);
    pause = 1'b1;
    repeat (7) begin
      cycle(); n++;
      chk("ps3_pause_count", 32'(cnt_o[2]), 6);
      chk("ps3_pause_active", 32'(act_o[2]), 1);
    end
    pause = 1'b0;
    got = 0;
    for (int k = 0; k < 100 && got == 0; k++) begin
      cycle(); n++;
      if (done_o[2]) got = 1;
    end
    chk("ps3_done_seen", got, 1);
    chk("ps3_done_edge", n, 38);
    chk("ps3_done_count", 32'(cnt_o[2]), 0);
    chk("ps3_done_active", 32'(act_o[2]), 0);
    drive(0, 1, 0, 0, 0);
    cycle();

    // PRESCALE=2 auto-reload, P=4: done every 8 cycles, preset change mid-run ignored
    for (int k = 1; k <= 40; k++) exp_q.push_back(W'(4 - ((k % 8) / 2)));
    drive(1, 0, 0, 1, 4);
    cycle();
    drive(0, 0, 0, 1, 4);
    for (int k = 1; k <= 40; k++) begin
      if (k == 17) begin preset_value = W'(9); auto_reload = 1'b0; end
      cycle();
      chk("ar_count", 32'(cnt_o[1]), 32'(exp_q.pop_front()));
      chk("ar_done", 32'(done_o[1]), (k % 8 == 0) ? 1 : 0);
    end
    chk("ar_period_cnt", 32'(pc_o[1]), 5);
    drive(0, 1, 0, 0, 0);
    cycle();

    // restart mid-run at count 3 after one completed period
    drive(1, 0, 0, 1, 4);
    cycle();
    drive(0, 0, 0, 0, 0);
    got = 0;
    for (int k = 0; k < 50 && got == 0; k++) begin
      cycle();
      if (pc_o[0] >= 1 && cnt_o[0] == 3) got = 1;
    end
    chk("restart_reached", got, 1);
    drive(1, 0, 0, 0, 10);
    cycle();
    chk("restart_count", 32'(cnt_o[0]), 10);
    chk("restart_period", 32'(pc_o[0]), 0);
    drive(0, 0, 0, 0, 0);

    // asynchronous reset at count 7, no edge needed
    got = 0;
    for (int k = 0; k < 50 && got == 0; k++) begin
      cycle();
      if (cnt_o[0] == 7) got = 1;
    end
    chk("areset_reached", got, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("areset_count", 32'(cnt_o[0]), 0);
    chk("areset_active", 32'(act_o[0]), 0);
    chk("areset_period", 32'(pc_o[0]), 0);
    compare_model();
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();

    // randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      drive($urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9));
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_model();
      end
      cycle();
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
